// File: rtl/uart_rx_ecc_decoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_ecc_decoder_if                                               |
// | UART byte input and decoded-nibble valid/ready output bundle.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_rx_ecc_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_perr;
  logic [3:0] out_data;
  logic       out_corr;
  logic       out_valid;
  logic       out_ready;

  // master: UART receiver plus downstream consumer; slave: the decoder
  modport master (
    output rx_data, rx_done, rx_perr, out_ready,
    input  out_data, out_corr, out_valid
  );
  modport slave (
    input  rx_data, rx_done, rx_perr, out_ready,
    output out_data, out_corr, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ecc_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_ecc_decoder                                                  |
// | Hamming(8,4) SECDED decode of UART bytes into a nibble FIFO.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx_ecc_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_ecc_decoder_if.slave bus,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt,
  output logic [CNT_W-1:0]     perr_cnt,
  output logic                 ovf
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam int              c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic             r_sync1, r_sync2, r_hist;
  logic             r_stg_vld, r_stg_perr;
  logic [7:0]       r_stg_data;
  logic [4:0]       r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic [3:0]       r_out_data;
  logic             r_out_corr, r_out_valid;
  logic [CNT_W-1:0] r_corr_cnt, r_uncorr_cnt, r_perr_cnt;
  logic             r_ovf;

  logic             w_rise;
  logic [2:0]       w_s;
  logic             w_q;
  logic [3:0]       w_nib;
  logic             w_ecc_vld, w_push, w_corr, w_uncorr, w_perr;
  logic             w_full, w_rd, w_wr, w_drop;
  logic [c_CW-1:0]  w_cnt_after_rd, w_cnt_nxt;
  logic [c_AW-1:0]  w_rd_ptr_nxt;

  assign w_rise = r_sync2 & ~r_hist;

  // Syndrome over the stage byte; each data bit flips only when the
  // syndrome points at its own codeword position.
  assign w_s     = {^(r_stg_data & 8'h78), ^(r_stg_data & 8'h66), ^(r_stg_data & 8'h55)};
  assign w_q     = ^r_stg_data;
  assign w_nib   = {r_stg_data[6] ^ (w_s == 3'd7),
                    r_stg_data[5] ^ (w_s == 3'd6),
                    r_stg_data[4] ^ (w_s == 3'd5),
                    r_stg_data[2] ^ (w_s == 3'd3)};

  assign w_perr    = r_stg_vld & r_stg_perr;
  assign w_ecc_vld = r_stg_vld & ~r_stg_perr;
  assign w_uncorr  = w_ecc_vld & (w_s != 3'd0) & ~w_q;
  assign w_corr    = w_ecc_vld & w_q;
  assign w_push    = w_ecc_vld & ~w_uncorr;

  assign w_full         = (r_count == c_FULL);
  assign w_rd           = r_out_valid & bus.out_ready;
  assign w_wr           = w_push & (~w_full | w_rd);
  assign w_drop         = w_push & w_full & ~w_rd;
  assign w_cnt_after_rd = r_count - c_CW'(w_rd);
  assign w_cnt_nxt      = w_cnt_after_rd + c_CW'(w_wr);
  assign w_rd_ptr_nxt   = r_rd_ptr + c_AW'(w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_hist     <= 1'b1;
      r_stg_vld  <= 1'b0;
      r_stg_perr <= 1'b0;
      r_stg_data <= 8'd0;
    end else begin
      r_sync1   <= bus.rx_done;
      r_sync2   <= r_sync1;
      r_hist    <= r_sync2;
      r_stg_vld <= w_rise;
      if (w_rise) begin
        r_stg_data <= bus.rx_data;
        r_stg_perr <= bus.rx_perr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_corr, w_nib};
  end

  // The head register is fed by the incoming frame when the FIFO would
  // otherwise be empty, so a push into an empty FIFO is visible at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_data  <= 4'd0;
      r_out_corr  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + c_AW'(w_wr);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_cnt_nxt;
      if (w_cnt_nxt == '0) begin
        r_out_valid <= 1'b0;
      end else if (w_cnt_after_rd == '0) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_nib;
        r_out_corr  <= w_corr;
      end else begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem[w_rd_ptr_nxt][3:0];
        r_out_corr  <= r_mem[w_rd_ptr_nxt][4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
      r_perr_cnt   <= '0;
      r_ovf        <= 1'b0;
    end else if (clr_cnt) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
      r_perr_cnt   <= '0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_corr && r_corr_cnt != '1)     r_corr_cnt   <= r_corr_cnt + CNT_W'(1);
      if (w_uncorr && r_uncorr_cnt != '1) r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
      if (w_perr && r_perr_cnt != '1)     r_perr_cnt   <= r_perr_cnt + CNT_W'(1);
      if (w_drop)                         r_ovf        <= 1'b1;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_corr  = r_out_corr;
  assign bus.out_valid = r_out_valid;
  assign corr_cnt      = r_corr_cnt;
  assign uncorr_cnt    = r_uncorr_cnt;
  assign perr_cnt      = r_perr_cnt;
  assign ovf           = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ecc_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_ecc_decoder                                               |
// | Directed self-checking bench for the SECDED UART nibble decoder.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_rx_ecc_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt, perr_cnt;
  logic             ovf;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_ecc_decoder_if u_if ();

  uart_rx_ecc_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (u_if),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt),
    .perr_cnt   (perr_cnt),
    .ovf        (ovf)
  );

  always #21 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_cnts(input string tag, input int c, input int u, input int p, input int o);
    check({tag, ".corr_cnt"},   32'(corr_cnt),   32'(c));
    check({tag, ".uncorr_cnt"}, 32'(uncorr_cnt), 32'(u));
    check({tag, ".perr_cnt"},   32'(perr_cnt),   32'(p));
    check({tag, ".ovf"},        32'(ovf),        32'(o));
  endtask

  // Entered and left on a falling edge; rx_done held high for 6 cycles.
  task automatic send(input logic [7:0] data, input logic perr);
    @(negedge clk);
    u_if.rx_data = data;
    u_if.rx_perr = perr;
    u_if.rx_done = 1'b1;
    repeat (6) @(negedge clk);
    u_if.rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [3:0] d, input logic c);
    check({tag, ".valid"}, 32'(u_if.out_valid), 32'd1);
    check({tag, ".data"},  32'(u_if.out_data),  32'(d));
    check({tag, ".corr"},  32'(u_if.out_corr),  32'(c));
    u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    u_if.rx_data   = 8'h00;
    u_if.rx_done   = 1'b0;
    u_if.rx_perr   = 1'b0;
    u_if.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst.valid", 32'(u_if.out_valid), 32'd0);
    check("rst.data",  32'(u_if.out_data),  32'd0);
    check("rst.corr",  32'(u_if.out_corr),  32'd0);
    check_cnts("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean 0x55 -> 0xB, visible right after the fourth rising edge.
    u_if.rx_data = 8'h55;
    u_if.rx_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("lat.before", 32'(u_if.out_valid), 32'd0);
    @(posedge clk);
    #1 check("lat.valid", 32'(u_if.out_valid), 32'd1);
    check("clean.data", 32'(u_if.out_data), 32'hB);
    check("clean.corr", 32'(u_if.out_corr), 32'd0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    u_if.rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_cnts("clean", 0, 0, 0, 0);
    u_if.out_ready = 1'b1;
    @(negedge clk);
    check("pop.last", 32'(u_if.out_valid), 32'd0);
    @(negedge clk);
    u_if.out_ready = 1'b0;   // second cycle was a read of an empty FIFO

    send(8'h45, 1'b0);
    pop_expect("sec", 4'hB, 1'b1);
    check("sec.empty", 32'(u_if.out_valid), 32'd0);
    check("sec.corr_cnt", 32'(corr_cnt), 32'd1);
    send(8'hD5, 1'b0);
    pop_expect("p0", 4'hB, 1'b1);
    check("p0.corr_cnt", 32'(corr_cnt), 32'd2);

    send(8'h44, 1'b0);
    check("ded.valid", 32'(u_if.out_valid), 32'd0);
    send(8'h00, 1'b1);
    check("perr.valid", 32'(u_if.out_valid), 32'd0);
    check_cnts("drops", 2, 1, 1, 0);
    pulse_clr();
    check_cnts("clr", 0, 0, 0, 0);

    // Five clean frames into a four-deep FIFO with the consumer stalled.
    repeat (5) send(8'h00, 1'b0);
    check("ovf.valid", 32'(u_if.out_valid), 32'd1);
    check_cnts("ovf", 0, 0, 0, 1);
    pulse_clr();
    check("ovf.clr", 32'(ovf), 32'd0);

    // Read lands on the same edge as the push into the full FIFO.
    @(negedge clk);
    u_if.rx_data = 8'h55;
    u_if.rx_done = 1'b1;
    repeat (3) @(negedge clk);
    u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    u_if.rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("fullrw.ovf", 32'(ovf), 32'd0);
    pop_expect("fullrw0", 4'h0, 1'b0);
    pop_expect("fullrw1", 4'h0, 1'b0);
    pop_expect("fullrw2", 4'h0, 1'b0);
    pop_expect("fullrw3", 4'hB, 1'b0);
    check("fullrw.empty", 32'(u_if.out_valid), 32'd0);

    // Counter saturation at 3, then a clear colliding with a decode.
    repeat (3) send(8'h44, 1'b0);
    check("sat.3", 32'(uncorr_cnt), 32'd3);
    repeat (2) send(8'h44, 1'b0);
    check("sat.hold", 32'(uncorr_cnt), 32'd3);
    @(negedge clk);
    u_if.rx_data = 8'h44;
    u_if.rx_done = 1'b1;
    repeat (3) @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("sat.clr", 32'(uncorr_cnt), 32'd0);
    repeat (2) @(negedge clk);
    u_if.rx_done = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h44, 1'b0);
    check("sat.after", 32'(uncorr_cnt), 32'd1);

    // Reset with two entries queued and rx_done still high.
    send(8'h55, 1'b0);
    @(negedge clk);
    u_if.rx_data = 8'h55;
    u_if.rx_done = 1'b1;
    repeat (6) @(negedge clk);
    pop_expect("mid.head", 4'hB, 1'b0);
    check("mid.queued", 32'(u_if.out_valid), 32'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid.rst", 32'(u_if.out_valid), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("mid.norise", 32'(u_if.out_valid), 32'd0);
    check_cnts("mid", 0, 0, 0, 0);
    u_if.rx_done = 1'b0;
    repeat (3) @(negedge clk);
    send(8'hD5, 1'b0);
    pop_expect("mid.next", 4'hB, 1'b1);
    check("mid.corr_cnt", 32'(corr_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
